// File: rtl/mem_resp_pkg.sv
// Shared types and sizing helpers for the memory responder.
// The response stage struct is sized for the default word width; the
// top rebuilds the same layout at its own MEM_W and hands it to the
// delay line as a type parameter.
package mem_resp_pkg;

  function automatic int bytes_per_word(input int mem_w);
    return mem_w / 8;
  endfunction

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int MEM_W_DEF      = 32;
  localparam int DEPTH_DEF      = 1024;
  localparam int BYTES_PER_WORD = bytes_per_word(MEM_W_DEF);
  localparam int IDX_W          = idx_width(DEPTH_DEF);

  typedef struct packed {
    logic                 valid;
    logic                 err;
    logic [MEM_W_DEF-1:0] rdata;
  } resp_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus of the memory responder. The requester uses the
// master modport, the responder the slave modport.
interface mem_responder_if #(
  parameter int MEM_W = 32
);
  logic               mem_req_i;
  logic [31:0]        mem_addr_i;
  logic               mem_we_i;
  logic [MEM_W/8-1:0] mem_be_i;
  logic [MEM_W-1:0]   mem_wdata_i;
  logic               mem_rvalid_o;
  logic               mem_err_o;
  logic [MEM_W-1:0]   mem_rdata_o;

  modport master (
    output mem_req_i, mem_addr_i, mem_we_i, mem_be_i, mem_wdata_i,
    input  mem_rvalid_o, mem_err_o, mem_rdata_o
  );

  modport slave (
    input  mem_req_i, mem_addr_i, mem_we_i, mem_be_i, mem_wdata_i,
    output mem_rvalid_o, mem_err_o, mem_rdata_o
  );
endinterface

// File: rtl/mem_resp_delay.sv
// Fixed-latency response delay line. Stage 0 loads the response built in
// the accept cycle, the last stage drives the bus. A reset cycle wipes
// every stage so responses in flight are never emitted.
module mem_resp_delay
  import mem_resp_pkg::*;
#(
  parameter int  LATENCY = 1,
  parameter type stage_t = resp_t
) (
  input  logic   clk,
  input  logic   rst,
  input  stage_t in_i,
  output stage_t out_o
);

  stage_t [LATENCY-1:0] stage_q;
  stage_t [LATENCY-1:0] stage_d;

  // shift the pipe by one stage, new response enters at stage 0
  always_comb begin
    stage_d    = '0;
    stage_d[0] = in_i;
    for (int i = 1; i < LATENCY; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // stage registers with synchronous flush
  always_ff @(posedge clk) begin
    if (rst) stage_q <= '0;
    else     stage_q <= stage_d;
  end

  assign out_o = stage_q[LATENCY-1];

endmodule

// File: rtl/mem_responder.sv
// Single-port memory responder: accepts one request per cycle, no
// backpressure, answers every accepted request after LATENCY cycles in
// order. Storage is never reset.
// Optional build macro MEM_RESPONDER_ERR_EN: out-of-window or misaligned
// addresses are rejected with mem_err_o=1 and no write. Without it the
// low address bits are ignored and the word index wraps.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int          MEM_W     = MEM_W_DEF,
  parameter int          DEPTH     = DEPTH_DEF,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LATENCY   = 1
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);

  localparam int BPW   = bytes_per_word(MEM_W);
  localparam int OFF_W = $clog2(BPW);
  localparam int AW    = idx_width(DEPTH);

  typedef struct packed {
    logic             valid;
    logic             err;
    logic [MEM_W-1:0] rdata;
  } stage_t;

  logic [MEM_W-1:0] mem_q [DEPTH];

  logic [32:0]   offset;
  logic [AW-1:0] idx;
  logic          accept;
  logic          addr_err;
  logic          wr_en;
  stage_t        resp_d;
  stage_t        resp_out;
  logic          unused_offset;

  // byte offset from the window base (bit 32 = below base) and word index
  always_comb begin
    offset = {1'b0, bus.mem_addr_i} - {1'b0, BASE_ADDR};
    idx    = AW'(offset[31:0] >> OFF_W);
    accept = bus.mem_req_i && !rst;
  end

  // the index deliberately drops the upper offset bits
  assign unused_offset = ^offset;

`ifdef MEM_RESPONDER_ERR_EN
  localparam logic [32:0] SPAN     = 33'(DEPTH) << OFF_W;
  localparam logic [31:0] OFF_MASK = 32'(BPW - 1);

  // reject below base, at/after window end, or not word aligned
  always_comb begin
    addr_err = offset[32]
            || ({1'b0, offset[31:0]} >= SPAN)
            || ((offset[31:0] & OFF_MASK) != '0);
  end
`else
  assign addr_err = 1'b0;
`endif

  assign wr_en = accept && bus.mem_we_i && !addr_err;

  // byte-masked write at the accept edge
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BPW; b++) begin
        if (bus.mem_be_i[b]) mem_q[idx][b*8 +: 8] <= bus.mem_wdata_i[b*8 +: 8];
      end
    end
  end

  // response built from storage as it stands before this edge's write
  always_comb begin
    resp_d = '0;
    if (accept) begin
      resp_d.valid = 1'b1;
      resp_d.err   = addr_err;
      if (!bus.mem_we_i && !addr_err) resp_d.rdata = mem_q[idx];
    end
  end

  mem_resp_delay #(
    .LATENCY (LATENCY),
    .stage_t (stage_t)
  ) u_delay (
    .clk   (clk),
    .rst   (rst),
    .in_i  (resp_d),
    .out_o (resp_out)
  );

  assign bus.mem_rvalid_o = resp_out.valid;
  assign bus.mem_err_o    = resp_out.err;
  assign bus.mem_rdata_o  = resp_out.rdata;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance at LATENCY=1, one at LATENCY=3,
// each with a reference memory and an expected-response queue tagged
// with the cycle the response is due.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst3;

  mem_responder_if #(.MEM_W(32)) bus1 ();
  mem_responder_if #(.MEM_W(32)) bus3 ();

  mem_responder #(.LATENCY(1)) dut1 (.clk(clk), .rst(rst1), .bus(bus1.slave));
  mem_responder #(.LATENCY(3)) dut3 (.clk(clk), .rst(rst3), .bus(bus3.slave));

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        q1[$];
  exp_t        q3[$];
  logic [31:0] model [2][1024];
  int          cyc      = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  bit          mon_en   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // reference behaviour of one request; updates the model memory
  task automatic model_req(input int d, input logic we, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wd,
                           input int lat, output exp_t e);
    bit       bad;
    int       idx;
    bad     = 0;
`ifdef MEM_RESPONDER_ERR_EN
    bad     = (addr >= 32'h1000) || (addr[1:0] != 2'b00);
`endif
    idx     = int'(addr[11:2]);
    e.due   = cyc + lat;
    e.err   = bad;
    e.rdata = '0;
    if (!bad) begin
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) model[d][idx][b*8 +: 8] = wd[b*8 +: 8];
      end else begin
        e.rdata = model[d][idx];
      end
    end
  endtask

  task automatic idle();
    bus1.mem_req_i = 0; bus1.mem_we_i = 0; bus1.mem_addr_i = '0; bus1.mem_be_i = '0; bus1.mem_wdata_i = '0;
    bus3.mem_req_i = 0; bus3.mem_we_i = 0; bus3.mem_addr_i = '0; bus3.mem_be_i = '0; bus3.mem_wdata_i = '0;
    rst1 = 0;
    rst3 = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  // present a request for the current cycle on instance d (0: lat1, 1: lat3)
  task automatic issue(input int d, input logic we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wd);
    exp_t e;
    if (d == 0) begin
      bus1.mem_req_i = 1; bus1.mem_we_i = we; bus1.mem_addr_i = addr; bus1.mem_be_i = be; bus1.mem_wdata_i = wd;
      if (!rst1) begin
        model_req(0, we, addr, be, wd, 1, e);
        q1.push_back(e);
      end
    end else begin
      bus3.mem_req_i = 1; bus3.mem_we_i = we; bus3.mem_addr_i = addr; bus3.mem_be_i = be; bus3.mem_wdata_i = wd;
      if (!rst3) begin
        model_req(1, we, addr, be, wd, 3, e);
        q3.push_back(e);
      end
    end
  endtask

  // reset for the current cycle; anything not yet visible is lost
  task automatic do_reset(input int d);
    if (d == 0) begin
      rst1 = 1;
      while (q1.size() > 0 && q1[$].due > cyc) void'(q1.pop_back());
    end else begin
      rst3 = 1;
      while (q3.size() > 0 && q3[$].due > cyc) void'(q3.pop_back());
    end
  endtask

  task automatic monitor(input int d);
    logic        rv, er;
    logic [31:0] rd;
    exp_t        e;
    bit          have;
    string       nm;
    nm   = (d == 0) ? "lat1" : "lat3";
    rv   = (d == 0) ? bus1.mem_rvalid_o : bus3.mem_rvalid_o;
    er   = (d == 0) ? bus1.mem_err_o    : bus3.mem_err_o;
    rd   = (d == 0) ? bus1.mem_rdata_o  : bus3.mem_rdata_o;
    have = 0;
    if (d == 0) begin
      if (q1.size() > 0 && q1[0].due < cyc) begin
        chk({nm, "_missed_resp"}, 64'(cyc), 64'(q1[0].due));
        void'(q1.pop_front());
      end
      if (rv && q1.size() > 0) begin e = q1.pop_front(); have = 1; end
    end else begin
      if (q3.size() > 0 && q3[0].due < cyc) begin
        chk({nm, "_missed_resp"}, 64'(cyc), 64'(q3[0].due));
        void'(q3.pop_front());
      end
      if (rv && q3.size() > 0) begin e = q3.pop_front(); have = 1; end
    end
    if (rv && !have) begin
      chk({nm, "_spurious_rvalid"}, 64'(rv), 64'(0));
    end else if (rv) begin
      chk({nm, "_due_cycle"}, 64'(cyc), 64'(e.due));
      chk({nm, "_err"}, 64'(er), 64'(e.err));
      chk({nm, "_rdata"}, 64'(rd), 64'(e.rdata));
    end else begin
      chk({nm, "_idle_err"}, 64'(er), 64'(0));
      chk({nm, "_idle_rdata"}, 64'(rd), 64'(0));
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      monitor(0);
      monitor(1);
    end
  end

  initial begin
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 1024; i++) model[d][i] = '0;
    idle();
    rst1 = 1;
    rst3 = 1;
    repeat (3) @(posedge clk);
    #1;
    idle();
    chk("reset_rvalid1", 64'(bus1.mem_rvalid_o), 64'(0));
    chk("reset_rvalid3", 64'(bus3.mem_rvalid_o), 64'(0));
    chk("reset_rdata3",  64'(bus3.mem_rdata_o),  64'(0));
    mon_en = 1;

    // write then read-after-write on the next cycle
    issue(0, 1, 32'h10, 4'hF, 32'hDEAD_BEEF);
    step(); issue(0, 0, 32'h10, 4'h0, 32'h0);
    repeat (3) step();

    // partial byte enables, then a write with no enables
    issue(0, 1, 32'h20, 4'hF, 32'h1122_3344);
    step(); issue(0, 1, 32'h20, 4'b0101, 32'hAABB_CCDD);
    step(); issue(0, 0, 32'h20, 4'h0, 32'h0);
    step(); issue(0, 1, 32'h20, 4'h0, 32'hFFFF_FFFF);
    step(); issue(0, 0, 32'h20, 4'h0, 32'h0);
    repeat (3) step();

    // LATENCY=3 streaming: 8 writes then 8 back-to-back reads
    for (int i = 0; i < 8; i++) begin
      issue(1, 1, 32'(i * 4), 4'hF, 32'h0101_0101 * 32'(i + 1));
      step();
    end
    for (int i = 0; i < 8; i++) begin
      issue(1, 0, 32'(i * 4), 4'h0, 32'h0);
      step();
    end
    repeat (5) step();

    // out-of-window and misaligned accesses
    issue(0, 1, 32'h0, 4'hF, 32'h0BAD_F00D);
    step(); issue(0, 0, 32'h1000, 4'h0, 32'h0);
    step(); issue(0, 1, 32'h0002, 4'hF, 32'h5555_AAAA);
    step(); issue(0, 0, 32'h0, 4'h0, 32'h0);
    repeat (3) step();

    // reset while two reads are in flight; read during reset is dropped
    issue(1, 0, 32'h0, 4'h0, 32'h0);
    step(); issue(1, 0, 32'h4, 4'h0, 32'h0);
    step(); do_reset(1); issue(1, 0, 32'h8, 4'h0, 32'h0);
    step(); issue(1, 0, 32'hC, 4'h0, 32'h0);
    repeat (5) step();

    // random traffic on a small window of both instances
    for (int i = 0; i < 16; i++) begin
      issue(0, 1, 32'(i * 4), 4'hF, $urandom);
      issue(1, 1, 32'(i * 4), 4'hF, $urandom);
      step();
    end
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) != 0)
        issue(0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15) * 4), 4'($urandom), $urandom);
      if ($urandom_range(0, 3) != 0)
        issue(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15) * 4), 4'($urandom), $urandom);
      step();
    end

    repeat (6) step();
    chk("drain_lat1", 64'(q1.size()), 64'(0));
    chk("drain_lat3", 64'(q3.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter MEM_W, 32, data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, 1024, number of MEM_W-bit words stored; SHALL be a power of 2.
REQ-003 Parameter BASE_ADDR, 32'h0000_0000, byte address of word 0; SHALL be DEPTH*MEM_W/8 aligned.
REQ-004 Parameter LATENCY, 1, cycles from request to response; legal range 1..4.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 mem_req_i  input  1  request valid; one request is accepted every cycle it is high.
REQ-008 mem_addr_i  input  32  byte address of the request.
REQ-009 mem_we_i  input  1  1 = write, 0 = read.
REQ-010 mem_be_i  input  MEM_W/8  byte enables for writes; ignored on reads.
REQ-011 mem_wdata_i  input  MEM_W  write data.
REQ-012 mem_rvalid_o  output  1  response valid, one pulse per accepted request.
REQ-013 mem_err_o  output  1  response error flag; qualified by mem_rvalid_o.
REQ-014 mem_rdata_o  output  MEM_W  read data; qualified by mem_rvalid_o.

Function
REQ-015 No backpressure: a request with mem_req_i=1 and rst=0 SHALL be accepted in that cycle.
REQ-016 Response for a request accepted at cycle N SHALL appear with mem_rvalid_o=1 at cycle N+LATENCY; responses SHALL be in request order.
REQ-017 Back-to-back requests SHALL yield back-to-back responses; throughput one per cycle.
REQ-018 Word index SHALL be (mem_addr_i - BASE_ADDR) >> log2(MEM_W/8), truncated to log2(DEPTH) bits.
REQ-019 Write: bytes with mem_be_i[i]=1 SHALL update at the accept edge; others unchanged; response has mem_rdata_o=0, mem_err_o=0.
REQ-020 Read: mem_rdata_o SHALL return the word as sampled at the accept edge, including a write accepted in the immediately preceding cycle.
REQ-021 Write with mem_be_i=0 SHALL leave storage unchanged and still produce a response.
REQ-022 mem_rvalid_o SHALL be 0 in every cycle not mapped by REQ-016; mem_rdata_o and mem_err_o SHALL be 0 whenever mem_rvalid_o=0.
REQ-023 Response pipeline: LATENCY stages, each holding {valid, err, rdata}; stage 0 loads at accept, stage LATENCY-1 drives the outputs.

Reset
REQ-024 With rst=1, all pipeline stages SHALL clear at the next edge; mem_rvalid_o=0, mem_err_o=0, mem_rdata_o=0.
REQ-025 A request presented while rst=1 SHALL be dropped: no write, no response.
REQ-026 Responses in flight when rst asserts SHALL be discarded, never emitted.
REQ-027 Storage contents SHALL NOT be reset.

Configuration
REQ-028 Macro MEM_RESPONDER_ERR_EN defined: a request with address outside [BASE_ADDR, BASE_ADDR+DEPTH*MEM_W/8), or with mem_addr_i not MEM_W/8-aligned, SHALL perform no write and respond with mem_err_o=1, mem_rdata_o=0.
REQ-029 Macro MEM_RESPONDER_ERR_EN undefined: mem_err_o SHALL be constant 0; low address bits are ignored and the index wraps per REQ-018.

Structure
REQ-030 Package mem_resp_pkg SHALL hold the response stage struct type {valid, err, rdata} and the constants for bytes per word and index width.
REQ-031 Sub-module mem_resp_delay SHALL implement the LATENCY-stage response pipeline with synchronous flush on rst; mem_responder holds storage, decode and error check.

Verification
REQ-032 LATENCY=1: write 0xDEADBEEF to 0x10 with be=0xF, then read 0x10 in the next cycle -> rvalid at cycle N+1 for the write (rdata 0), then at N+2 with rdata=0xDEADBEEF.
REQ-033 Word 0x20 holds 0x11223344; write 0xAABBCCDD with be=0b0101, then read -> 0x11BB33DD.
REQ-034 LATENCY=3: 8 back-to-back reads of 0x0..0x1C -> 8 consecutive rvalid cycles starting 3 cycles after the first request, data in order.
REQ-035 ERR_EN defined, DEPTH=1024: read 0x1000 and write 0x0002 -> both respond err=1, rdata=0, word 0 unchanged; ERR_EN undefined: read 0x1000 returns word 0, err=0.
REQ-036 LATENCY=3: issue 3 reads, assert rst for 1 cycle after the 2nd read -> no rvalid for any of them, outputs 0; a read issued after reset is answered normally.
